// File: rtl/keypad_pkg.sv
// Shared types and helpers for the matrix keypad reader.
package keypad_pkg;

  // Debounce FSM states.
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DEBOUNCE,
    ST_PRESSED
  } state_e;

  // Classification of one complete scan frame.
  typedef enum logic [1:0] {
    FR_NONE,
    FR_SINGLE,
    FR_MULTI
  } frame_res_e;

  // Width of a key code: clog2 of the key count, never below one bit.
  function automatic int cw(input int n_rows, input int n_cols);
    int n;
    n = n_rows * n_cols;
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/keypad_col_scan.sv
// Column ring, row synchronizer and per-frame press accumulation.
// One frame covers all columns; its result is published as a
// one-cycle frame_done pulse with the result class and first key code.
module keypad_col_scan
  import keypad_pkg::*;
#(
  parameter int N_COLS   = 4,
  parameter int N_ROWS   = 4,
  parameter int SCAN_DIV = 50000,
  parameter int CW       = cw(N_ROWS, N_COLS)
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [N_ROWS-1:0] row_n,
  output logic [N_COLS-1:0] col_n,
  output logic              frame_done,
  output frame_res_e        frame_result,
  output logic [CW-1:0]     frame_code
);

  localparam int DIVW = $clog2(SCAN_DIV);
  localparam int COLW = (N_COLS > 1) ? $clog2(N_COLS) : 1;
  localparam int RW   = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
  localparam logic [DIVW-1:0] DIV_LAST = DIVW'(SCAN_DIV - 1);
  localparam logic [COLW-1:0] COL_LAST = COLW'(N_COLS - 1);

  logic [N_ROWS-1:0] sync1_q, sync2_q;
  logic [DIVW-1:0]   div_q;
  logic [COLW-1:0]   col_q;
  logic [1:0]        acc_cnt_q;   // pressed count so far, saturates at 2
  logic [CW-1:0]     acc_code_q;  // code of first pressed key this frame
  logic              fdone_q;
  frame_res_e        fres_q;
  logic [CW-1:0]     fcode_q;

  logic              tick;
  logic [N_ROWS-1:0] row_hit;
  logic [1:0]        col_cnt;
  logic [RW-1:0]     first_row;
  logic [CW-1:0]     col_code;
  logic [2:0]        sum_cnt;
  logic [1:0]        tot_cnt;
  logic [CW-1:0]     new_code;

  assign tick    = (div_q == DIV_LAST);
  assign row_hit = ~sync2_q;
  assign col_n   = ~(N_COLS'(1) << col_q);

  // Count pressed rows in the driven column and pick the lowest one.
  always_comb begin
    col_cnt   = 2'd0;
    first_row = '0;
    for (int r = N_ROWS - 1; r >= 0; r--) begin
      if (row_hit[r]) begin
        first_row = RW'(r);
        if (col_cnt != 2'd2) col_cnt = col_cnt + 2'd1;
      end
    end
  end

  // Merge this column into the frame totals; the earliest key wins the code.
  always_comb begin
    col_code = CW'(col_q) * CW'(N_ROWS) + CW'(first_row);
    sum_cnt  = {1'b0, acc_cnt_q} + {1'b0, col_cnt};
    tot_cnt  = (sum_cnt >= 3'd2) ? 2'd2 : sum_cnt[1:0];
    new_code = (acc_cnt_q == 2'd0) ? col_code : acc_code_q;
  end

  // Two-flop synchronizer; idle level is all ones (rows pulled up).
  always_ff @(posedge clk) begin
    if (clr) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= row_n;
      sync2_q <= sync1_q;
    end
  end

  // Divider, column ring and frame accumulators.
  always_ff @(posedge clk) begin
    if (clr) begin
      div_q      <= '0;
      col_q      <= '0;
      acc_cnt_q  <= 2'd0;
      acc_code_q <= '0;
      fdone_q    <= 1'b0;
      fres_q     <= FR_NONE;
      fcode_q    <= '0;
    end else begin
      fdone_q <= 1'b0;
      div_q   <= tick ? '0 : div_q + DIVW'(1);
      if (tick) begin
        col_q <= (col_q == COL_LAST) ? '0 : col_q + COLW'(1);
        if (col_q == COL_LAST) begin
          fdone_q    <= 1'b1;
          fres_q     <= (tot_cnt == 2'd0) ? FR_NONE :
                        (tot_cnt == 2'd1) ? FR_SINGLE : FR_MULTI;
          fcode_q    <= new_code;
          acc_cnt_q  <= 2'd0;
          acc_code_q <= '0;
        end else begin
          acc_cnt_q  <= tot_cnt;
          acc_code_q <= new_code;
        end
      end
    end
  end

  assign frame_done   = fdone_q;
  assign frame_result = fres_q;
  assign frame_code   = fcode_q;

endmodule

// File: rtl/keypad_scanner.sv
// Matrix keypad reader: scans columns, debounces whole frames and
// reports one accepted key as a single-cycle strobe plus a held level.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int N_COLS   = 4,
  parameter int N_ROWS   = 4,
  parameter int SCAN_DIV = 50000,
  parameter int DEBOUNCE = 4,
  localparam int CW      = cw(N_ROWS, N_COLS)
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [N_ROWS-1:0] row_n,
  output logic [N_COLS-1:0] col_n,
  output logic [CW-1:0]     key_code,
  output logic              key_valid,
  output logic              key_held,
  output logic              key_multi
);

  localparam int DW = $clog2(DEBOUNCE + 1);
  localparam logic [DW-1:0] DB_MAX = DW'(DEBOUNCE);

  logic          frame_done;
  frame_res_e    frame_result;
  logic [CW-1:0] frame_code;

  keypad_col_scan #(
    .N_COLS  (N_COLS),
    .N_ROWS  (N_ROWS),
    .SCAN_DIV(SCAN_DIV),
    .CW      (CW)
  ) u_scan (
    .clk         (clk),
    .clr         (clr),
    .row_n       (row_n),
    .col_n       (col_n),
    .frame_done  (frame_done),
    .frame_result(frame_result),
    .frame_code  (frame_code)
  );

  state_e        state_q, state_d;
  logic [CW-1:0] cand_q, cand_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] rel_q, rel_d;
  logic [CW-1:0] code_q, code_d;
  logic          valid_q, valid_d;
  logic          held_q, held_d;
  logic          multi_q, multi_d;

  // State and output registers.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= ST_IDLE;
      cand_q  <= '0;
      cnt_q   <= '0;
      rel_q   <= '0;
      code_q  <= '0;
      valid_q <= 1'b0;
      held_q  <= 1'b0;
      multi_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      rel_q   <= rel_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      held_q  <= held_d;
      multi_q <= multi_d;
    end
  end

  // Debounce decisions, taken only when a frame completes.
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    rel_d   = rel_q;
    code_d  = code_q;
    valid_d = 1'b0;
    held_d  = held_q;
    multi_d = 1'b0;
    if (frame_done) begin
      unique case (state_q)
        ST_IDLE: begin
          if (frame_result == FR_SINGLE) begin
            cand_d = frame_code;
            cnt_d  = DW'(1);
            if (DEBOUNCE == 1) begin
              code_d  = frame_code;
              valid_d = 1'b1;
              held_d  = 1'b1;
              rel_d   = '0;
              state_d = ST_PRESSED;
            end else begin
              state_d = ST_DEBOUNCE;
            end
          end else if (frame_result == FR_MULTI) begin
            multi_d = 1'b1;
          end
        end
        ST_DEBOUNCE: begin
          if (frame_result == FR_SINGLE) begin
            if (frame_code == cand_q) begin
              if (cnt_q + DW'(1) == DB_MAX) begin
                code_d  = cand_q;
                valid_d = 1'b1;
                held_d  = 1'b1;
                rel_d   = '0;
                state_d = ST_PRESSED;
              end else begin
                cnt_d = cnt_q + DW'(1);
              end
            end else begin
              // A different key restarts the count from this frame.
              cand_d = frame_code;
              cnt_d  = DW'(1);
            end
          end else if (frame_result == FR_MULTI) begin
            multi_d = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_PRESSED: begin
          // Anything seen keeps the key down; no rollover to other keys.
          if (frame_result == FR_NONE) begin
            if (rel_q + DW'(1) == DB_MAX) begin
              rel_d   = '0;
              held_d  = 1'b0;
              state_d = ST_IDLE;
            end else begin
              rel_d = rel_q + DW'(1);
            end
          end else begin
            rel_d = '0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign key_code  = code_q;
  assign key_valid = valid_q;
  assign key_held  = held_q;
  assign key_multi = multi_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: a keypad model drives rows from
// the pressed-key set; expected key codes are queued by the stimulus and
// popped by a monitor whenever key_valid strobes.
module tb_keypad_scanner;

  localparam int N_COLS = 4, N_ROWS = 4, SCAN_DIV = 4, DEBOUNCE = 2;
  localparam int FR = N_COLS * SCAN_DIV;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic [3:0] row_n;
  logic [3:0] col_n;
  logic [3:0] key_code;
  logic       key_valid, key_held, key_multi;
  logic [15:0] keys = '0;

  keypad_scanner #(
    .N_COLS(N_COLS), .N_ROWS(N_ROWS), .SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE)
  ) dut (
    .clk(clk), .clr(clr), .row_n(row_n), .col_n(col_n),
    .key_code(key_code), .key_valid(key_valid),
    .key_held(key_held), .key_multi(key_multi)
  );

  always #5 clk = ~clk;

  // Keypad: a pressed key pulls its row low while its column is driven.
  always_comb begin
    row_n = '1;
    for (int c = 0; c < N_COLS; c++)
      for (int r = 0; r < N_ROWS; r++)
        if (!col_n[c] && keys[c*N_ROWS+r]) row_n[r] = 1'b0;
  end

  // Cycles since reset release, used to align presses to frame starts.
  int cyc;
  always @(posedge clk) if (clr) cyc <= 0; else cyc <= cyc + 1;

  int n_checks = 0, n_fail = 0;
  int valid_cnt = 0, multi_cnt = 0;
  logic [3:0] exp_q[$];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic monitor();
    int e;
    forever begin
      @(negedge clk);
      if (key_multi === 1'b1) multi_cnt++;
      if (key_valid === 1'b1) begin
        valid_cnt++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_valid: key_valid with code %0d, none expected", key_code);
        end else begin
          e = exp_q.pop_front();
          check("key_code", int'(key_code), e);
        end
      end
    end
  endtask

  task automatic align();
    while (cyc % FR != 0) @(negedge clk);
  endtask

  task automatic wait_valid(input int bound, output int lat);
    int v0;
    v0  = valid_cnt;
    lat = 0;
    while (valid_cnt == v0 && lat < bound) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic wait_held_low(input int bound, output int lat);
    lat = 0;
    while (key_held === 1'b1 && lat < bound) begin
      @(negedge clk);
      lat++;
    end
  endtask

  // Watch key_held over n cycles; report whether it ever had the given level.
  task automatic watch_held(input int n, input logic lvl, output int seen);
    seen = 0;
    repeat (n) begin
      @(negedge clk);
      if (key_held === lvl) seen = 1;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, seen, v0, m0;
    logic [3:0] ecol;
    fork
      monitor();
    join_none

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_col_n", int'(col_n), 4'b1110);
    check("rst_key_code", int'(key_code), 0);
    check("rst_key_valid", int'(key_valid), 0);
    check("rst_key_held", int'(key_held), 0);
    check("rst_key_multi", int'(key_multi), 0);

    // Idle scan: column ring steps every SCAN_DIV cycles.
    clr = 1'b0;
    for (int k = 0; k < FR; k++) begin
      ecol = ~(4'b0001 << (k / SCAN_DIV));
      check("col_n_seq", int'(col_n), int'(ecol));
      @(negedge clk);
    end
    watch_held(9 * FR, 1'b1, seen);
    check("idle_held", seen, 0);
    check("idle_multi", multi_cnt, 0);
    check("idle_valid", valid_cnt, 0);

    // Stable press of code 9 (col2,row1).
    align();
    keys[9] = 1'b1;
    exp_q.push_back(4'd9);
    wait_valid(4 * FR, lat);
    check_range("latency_9", lat, 2 * FR, 3 * FR + 2);
    v0 = valid_cnt;
    repeat (2 * FR) @(negedge clk);
    check("held_while_pressed", int'(key_held), 1);
    check("single_strobe_9", valid_cnt, v0);
    align();
    keys = '0;
    repeat (FR) @(negedge clk);
    check("held_after_1_release_frame", int'(key_held), 1);
    wait_held_low(3 * FR, lat);
    check_range("release_time", lat + FR, 2 * FR, 3 * FR + 2);

    // One-frame bounce of code 7: never accepted.
    align();
    v0 = valid_cnt;
    keys[7] = 1'b1;
    repeat (FR) @(negedge clk);
    keys = '0;
    watch_held(4 * FR, 1'b1, seen);
    check("bounce_held", seen, 0);
    check("bounce_valid", valid_cnt, v0);

    // Codes 0 and 5 together: key_multi once per frame.
    align();
    v0 = valid_cnt;
    m0 = multi_cnt;
    keys[0] = 1'b1;
    keys[5] = 1'b1;
    repeat (4 * FR) @(negedge clk);
    keys = '0;
    repeat (3 * FR) @(negedge clk);
    check("multi_pulses", multi_cnt - m0, 4);
    check("multi_no_valid", valid_cnt, v0);

    // No rollover: 9 accepted, 4 added, 9 released, 4 stays down.
    align();
    keys[9] = 1'b1;
    exp_q.push_back(4'd9);
    wait_valid(4 * FR, lat);
    check_range("latency_9b", lat, 2 * FR, 3 * FR + 2);
    align();
    keys[4] = 1'b1;
    repeat (2 * FR) @(negedge clk);
    align();
    v0 = valid_cnt;
    keys[9] = 1'b0;
    watch_held(4 * FR, 1'b0, seen);
    check("rollover_held_low", seen, 0);
    check("rollover_no_valid", valid_cnt, v0);
    align();
    keys = '0;
    repeat (3 * FR) @(negedge clk);
    check("released_all_held", int'(key_held), 0);
    align();
    keys[4] = 1'b1;
    exp_q.push_back(4'd4);
    wait_valid(4 * FR, lat);
    check_range("latency_4", lat, 2 * FR, 3 * FR + 2);
    keys = '0;
    repeat (3 * FR) @(negedge clk);
    check("released_4_held", int'(key_held), 0);

    // Reset while PRESSED with the key still down.
    align();
    keys[9] = 1'b1;
    exp_q.push_back(4'd9);
    wait_valid(4 * FR, lat);
    check_range("latency_9c", lat, 2 * FR, 3 * FR + 2);
    repeat (FR) @(negedge clk);
    check("held_before_clr", int'(key_held), 1);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("clr_key_code", int'(key_code), 0);
    check("clr_key_held", int'(key_held), 0);
    check("clr_key_valid", int'(key_valid), 0);
    check("clr_col_n", int'(col_n), 4'b1110);
    exp_q.push_back(4'd9);
    wait_valid(4 * FR, lat);
    check_range("latency_after_clr", lat, 2 * FR, 3 * FR + 2);
    keys = '0;
    repeat (3 * FR) @(negedge clk);
    check("pending_expected", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Matrix keypad reader for the irrigation controller board.
- It is the input-side counterpart of the column-scanned LED matrix and display drivers: it drives one keypad column at a time and reads back the rows.
- It debounces each scan frame and emits a single-cycle strobe carrying the code of one pressed key.
- Downstream logic (set-point entry, mode select) consumes the key_code/key_valid pair.

Parameters:
- N_COLS, 4: keypad columns driven.
- N_ROWS, 4: keypad rows sampled.
- SCAN_DIV, 50000: clk cycles per column step; also the settle time before sampling. Must be ≥2.
- DEBOUNCE, 4: consecutive identical frames required to accept a press or a release. Must be ≥1.

Ports:
- clk  in  1  system clock.
- clr  in  1  reset; synchronous, active-high.
- row_n  in  N_ROWS  keypad rows; active-low, pulled up externally; asynchronous to clk.
- col_n  out  N_COLS  column drive; one-hot active-low.
- key_code  out  CW  code of the accepted key, equal to col*N_ROWS+row. CW = clog2(N_ROWS*N_COLS).
- key_valid  out  1  one-cycle strobe when a new key is accepted.
- key_held  out  1  high while the accepted key is considered down.
- key_multi  out  1  one-cycle strobe when a frame with ≥2 pressed keys is seen while not in PRESSED.

Behaviour:
- Reset (clr=1 at a clk edge) sets:
  - col_n = all ones except bit0 = 0 (column 0 driven).
  - key_code=0, key_valid=0, key_held=0, key_multi=0.
  - Divider, column index, frame accumulators and debounce counter cleared.
  - FSM to IDLE.
  - Reset mid-frame or mid-debounce discards all partial state; no strobe is emitted in the reset cycle.
- Row input: row_n passes through a 2-flop synchronizer. Only the synchronized value is used.
- Scan:
  - The divider counts 0..SCAN_DIV-1; a tick occurs when it reaches SCAN_DIV-1.
  - On a tick, synchronized rows are sampled for the currently driven column, then the column index advances, wrapping N_COLS-1→0. col_n changes in the same cycle.
  - A frame is N_COLS ticks, i.e. N_COLS*SCAN_DIV cycles. The frame result is evaluated on the tick that samples column N_COLS-1.
- Frame result:
  - NONE: 0 rows low across all columns.
  - SINGLE(code): exactly 1 row low. Code uses that key's column and row.
  - MULTI: ≥2 rows low.
- FSM, evaluated on frame-end ticks only:
  - IDLE:
    - SINGLE(c): cand=c, cnt=1. If DEBOUNCE==1, accept immediately; else go to DEBOUNCE.
    - MULTI: pulse key_multi; stay in IDLE.
    - NONE: stay in IDLE.
  - DEBOUNCE:
    - SINGLE(cand): cnt++. When cnt==DEBOUNCE, accept.
    - SINGLE(other): restart with cand=other, cnt=1.
    - MULTI: pulse key_multi; go to IDLE.
    - NONE: go to IDLE.
  - Accept: key_code<=cand, key_valid=1 for exactly that cycle, key_held<=1, rel=0, go to PRESSED.
  - PRESSED:
    - NONE: rel++. When rel==DEBOUNCE, key_held<=0 and go to IDLE.
    - Any non-NONE result: rel=0.
    - Other keys and MULTI produce no strobe and no key_multi. There is no rollover: a new key requires a full release first.
- key_code holds its value until the next accept; it is stable whenever key_valid=1.
- Latency: from a stable press, key_valid rises between DEBOUNCE and DEBOUNCE+1 frames plus 2 cycles.
- Counter widths: clog2 of the terminal value. No counter overflows, since each saturates at its compare value.

Decomposition:
- Package keypad_pkg holds:
  - FSM state enum: IDLE, DEBOUNCE, PRESSED.
  - Frame result enum: NONE, SINGLE, MULTI.
  - Code width function cw(N_ROWS, N_COLS).
- Sub-module keypad_col_scan holds:
  - The row synchronizer, divider, and column ring.
  - Per-frame accumulation of the pressed count and first code.
  - Outputs: col_n, frame_done pulse, frame_result, frame_code.
- The top level holds the debounce FSM and the output registers.

Test Plan (N_COLS=4, N_ROWS=4, SCAN_DIV=4, DEBOUNCE=2; frame=16 clk):
- Reset release, no key pressed → col_n cycles 1110, 1101, 1011, 0111, changing every 4 clk. key_valid, key_held and key_multi stay 0 for 10 frames.
- Key col2,row1 held (row_n[1]=0 only while col_n[2]=0) → exactly one key_valid pulse with key_code=9 after 2–3 frames. key_held=1 until 2 full NONE frames after release, then 0.
- Key col1,row3 present for 1 frame then released → no key_valid, key_held stays 0.
- Keys code 0 and code 5 pressed together from IDLE → key_multi pulses once per frame, no key_valid.
- Code 9 accepted, then code 4 added and held, then code 9 released while 4 stays down → no new key_valid while 4 is held. Release all for 2 frames; then pressing 4 yields key_valid with code 4.
- clr asserted for 1 cycle during PRESSED (code 9 still pressed) → outputs zero next cycle. key_valid re-fires with code 9 after 2–3 frames.
